wb_master: RTL and testbench

Wishbone classic-cycle initiator that turns single-word commands from a local valid/ready port into Wishbone bus cycles and returns one response per command. It sits between a bus-facing controller (GPIO bridge, test sequencer) and any Wishbone slave on the MPSoC interconnect. It handles retry, error and timeout termination, and drives only single, non-burst transfers.

---
 rtl/wb_master.sv | 184 ++++++++++++++++++
 tb/tb_wb_master.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/wb_master.sv
// wb_master: Wishbone classic-cycle initiator. Each accepted command becomes
// one single (non-burst) Wishbone transfer, with retry, error and timeout
// termination. Exactly one response is returned per command.
module wb_master #(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int MAX_RETRY = 3,
  parameter int TIMEOUT   = 255,
  localparam int SW       = DW / 8
) (
  input  logic          clk,
  input  logic          rst,
  // local command port
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_we,
  input  logic [AW-1:0] cmd_adr,
  input  logic [DW-1:0] cmd_dat,
  input  logic [SW-1:0] cmd_sel,
  // local response port
  output logic          rsp_valid,
  output logic [1:0]    rsp_status,
  output logic [DW-1:0] rsp_dat,
  // Wishbone initiator port
  output logic [AW-1:0] adr_o,
  output logic [DW-1:0] dat_o,
  output logic [SW-1:0] sel_o,
  output logic          we_o,
  output logic          cyc_o,
  output logic          stb_o,
  output logic [2:0]    cti_o,
  output logic [1:0]    bte_o,
  input  logic [DW-1:0] dat_i,
  input  logic          ack_i,
  input  logic          err_i,
  input  logic          rty_i
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUS  = 2'd1,
    S_GAP  = 2'd2,
    S_RESP = 2'd3
  } state_e;

  localparam int            RW        = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);
  localparam logic [15:0]   WAIT_LAST = 16'(TIMEOUT - 1);
  localparam logic [15:0]   WAIT_SAT  = 16'hFFFF;

  localparam logic [1:0] ST_OK  = 2'd0;
  localparam logic [1:0] ST_ERR = 2'd1;
  localparam logic [1:0] ST_RTY = 2'd2;
  localparam logic [1:0] ST_TMO = 2'd3;

  state_e        state_q, state_d;
  logic [RW-1:0] retry_q, retry_d;
  logic [15:0]   wait_q, wait_d;
  logic [AW-1:0] adr_q, adr_d;
  logic [DW-1:0] dat_q, dat_d;
  logic [SW-1:0] sel_q, sel_d;
  logic          we_q, we_d;
  logic          cyc_q, cyc_d;
  logic          rdy_q, rdy_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [1:0]    status_q, status_d;
  logic [DW-1:0] rsp_dat_q, rsp_dat_d;

  // Next-state and next-output logic; every output register is loaded from here.
  always_comb begin
    state_d     = state_q;
    retry_d     = retry_q;
    wait_d      = wait_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    sel_d       = sel_q;
    we_d        = we_q;
    status_d    = status_q;
    rsp_dat_d   = rsp_dat_q;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid && rdy_q) begin
          adr_d   = cmd_adr;
          dat_d   = cmd_we ? cmd_dat : '0;
          sel_d   = (cmd_sel == '0) ? '1 : cmd_sel;
          we_d    = cmd_we;
          retry_d = '0;
          wait_d  = 16'd0;
          state_d = S_BUS;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_BUS: begin
        // Termination priority: err > rty > ack.
        if (err_i) begin
          status_d  = ST_ERR;
          rsp_dat_d = '0;
          state_d   = S_RESP;
        end else if (rty_i) begin
          if (retry_q < RETRY_MAX) begin
            retry_d = retry_q + 1'b1;
            wait_d  = 16'd0;
            state_d = S_GAP;
          end else begin
            status_d  = ST_RTY;
            rsp_dat_d = '0;
            state_d   = S_RESP;
          end
        end else if (ack_i) begin
          status_d  = ST_OK;
          rsp_dat_d = we_q ? '0 : dat_i;
          state_d   = S_RESP;
        end else if (wait_q == WAIT_LAST) begin
          status_d  = ST_TMO;
          rsp_dat_d = '0;
          state_d   = S_RESP;
        end else begin
          wait_d  = (wait_q == WAIT_SAT) ? wait_q : wait_q + 16'd1;
          state_d = S_BUS;
        end
      end
      S_GAP: begin
        state_d = S_BUS;
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    cyc_d       = (state_d == S_BUS);
    rdy_d       = (state_d == S_IDLE);
    rsp_valid_d = (state_d == S_RESP);
  end

  // State, counters, latched command and all output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      retry_q     <= '0;
      wait_q      <= 16'd0;
      adr_q       <= '0;
      dat_q       <= '0;
      sel_q       <= '0;
      we_q        <= 1'b0;
      cyc_q       <= 1'b0;
      rdy_q       <= 1'b1;
      rsp_valid_q <= 1'b0;
      status_q    <= 2'd0;
      rsp_dat_q   <= '0;
    end else begin
      state_q     <= state_d;
      retry_q     <= retry_d;
      wait_q      <= wait_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      sel_q       <= sel_d;
      we_q        <= we_d;
      cyc_q       <= cyc_d;
      rdy_q       <= rdy_d;
      rsp_valid_q <= rsp_valid_d;
      status_q    <= status_d;
      rsp_dat_q   <= rsp_dat_d;
    end
  end

  assign cmd_ready  = rdy_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_status = status_q;
  assign rsp_dat    = rsp_dat_q;
  assign adr_o      = adr_q;
  assign dat_o      = dat_q;
  assign sel_o      = sel_q;
  assign we_o       = we_q;
  assign cyc_o      = cyc_q;
  assign stb_o      = cyc_q;
  assign cti_o      = 3'b000;
  assign bte_o      = 2'b00;

endmodule

// File: tb/tb_wb_master.sv
// Directed self-checking bench for wb_master (MAX_RETRY=3, TIMEOUT=8).
// Inputs change and outputs are sampled on the falling edge.
module tb_wb_master;
  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_we;
  logic [31:0] cmd_adr, cmd_dat;
  logic [3:0]  cmd_sel;
  logic        rsp_valid;
  logic [1:0]  rsp_status;
  logic [31:0] rsp_dat;
  logic [31:0] adr_o, dat_o, dat_i;
  logic [3:0]  sel_o;
  logic        we_o, cyc_o, stb_o, ack_i, err_i, rty_i;
  logic [2:0]  cti_o;
  logic [1:0]  bte_o;

  int errors = 0;
  int checks = 0;

  // results of the last run_txn
  int          r_lat, r_cyc_hi, r_phases, r_gaps, r_rsp_cnt;
  logic [1:0]  r_status;
  logic [31:0] r_dat, r_adr, r_dat_o;
  logic [3:0]  r_sel;
  bit          r_we_bad, r_stb_bad;

  wb_master #(.AW(32), .DW(32), .MAX_RETRY(3), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_adr(cmd_adr), .cmd_dat(cmd_dat), .cmd_sel(cmd_sel),
    .rsp_valid(rsp_valid), .rsp_status(rsp_status), .rsp_dat(rsp_dat),
    .adr_o(adr_o), .dat_o(dat_o), .sel_o(sel_o), .we_o(we_o),
    .cyc_o(cyc_o), .stb_o(stb_o), .cti_o(cti_o), .bte_o(bte_o),
    .dat_i(dat_i), .ack_i(ack_i), .err_i(err_i), .rty_i(rty_i)
  );

  always #5 clk = ~clk;

  // Issue one command and play the slave: each bus phase terminates after
  // 'waits' wait cycles; the first n_rty attempts answer rty, then err+ack
  // (do_err) or ack with rdata. A silent slave never terminates.
  task automatic run_txn(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, input int waits, input int n_rty,
                         input logic do_err, input logic silent, input logic [31:0] rdata);
    int  phase_len = 0;
    int  attempt   = 0;
    bit  prev_cyc  = 1'b0;
    r_lat = 0; r_cyc_hi = 0; r_phases = 0; r_gaps = 0; r_rsp_cnt = 0;
    r_status = 2'd0; r_dat = 32'd0; r_adr = 32'd0; r_dat_o = 32'd0; r_sel = 4'd0;
    r_we_bad = 1'b0; r_stb_bad = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_we = we; cmd_adr = adr; cmd_dat = dat; cmd_sel = sel;
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      ack_i = 1'b0; err_i = 1'b0; rty_i = 1'b0; dat_i = 32'hA5A5_A5A5;
      if (stb_o !== cyc_o) r_stb_bad = 1'b1;
      if (rsp_valid) begin
        r_rsp_cnt++;
        if (r_lat == 0) begin
          r_lat = k; r_status = rsp_status; r_dat = rsp_dat;
        end
      end
      if (cyc_o) begin
        r_cyc_hi++;
        r_adr = adr_o; r_dat_o = dat_o; r_sel = sel_o;
        if (we_o !== we) r_we_bad = 1'b1;
        if (!prev_cyc) begin
          r_phases++;
          phase_len = 0;
        end
        if (!silent && phase_len == waits) begin
          if (attempt < n_rty) rty_i = 1'b1;
          else if (do_err) begin err_i = 1'b1; ack_i = 1'b1; end
          else begin ack_i = 1'b1; dat_i = rdata; end
          attempt++;
        end
        phase_len++;
      end else if (r_phases > 0 && r_lat == 0) begin
        r_gaps++;
      end
      prev_cyc = cyc_o;
      if (r_lat != 0 && k >= r_lat + 2) break;
      @(negedge clk);
    end
    ack_i = 1'b0; err_i = 1'b0; rty_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (cyc_o !== 1'b0 || stb_o !== 1'b0 || we_o !== 1'b0 || rsp_valid !== 1'b0) begin
      errors++; $display("FAIL reset_ctrl: cyc=%b stb=%b we=%b rsp_valid=%b, required all 0", cyc_o, stb_o, we_o, rsp_valid);
    end
    checks++; if (adr_o !== 32'd0 || dat_o !== 32'd0 || sel_o !== 4'd0 || rsp_dat !== 32'd0 || rsp_status !== 2'd0) begin
      errors++; $display("FAIL reset_data: adr=%h dat=%h sel=%h rsp_dat=%h st=%0d, required all 0", adr_o, dat_o, sel_o, rsp_dat, rsp_status);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (cmd_ready !== 1'b1 || cti_o !== 3'b000 || bte_o !== 2'b00) begin
      errors++; $display("FAIL reset_ready: ready=%b cti=%b bte=%b, required 1/000/00", cmd_ready, cti_o, bte_o);
    end
  endtask

  task automatic test_write();
    run_txn(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 1, 0, 1'b0, 1'b0, 32'd0);
    checks++; if (r_cyc_hi !== 2 || r_lat !== 3) begin
      errors++; $display("FAIL write_timing: cyc_high=%0d lat=%0d, required 2/3", r_cyc_hi, r_lat);
    end
    checks++; if (r_status !== 2'd0 || r_dat !== 32'd0 || r_rsp_cnt !== 1) begin
      errors++; $display("FAIL write_rsp: st=%0d dat=%h pulses=%0d, required 0/0/1", r_status, r_dat, r_rsp_cnt);
    end
    checks++; if (r_adr !== 32'h10 || r_dat_o !== 32'hDEAD_BEEF || r_sel !== 4'hF || r_we_bad || r_stb_bad) begin
      errors++; $display("FAIL write_bus: adr=%h dat=%h sel=%h we_bad=%b stb_bad=%b, required 10/deadbeef/f/0/0", r_adr, r_dat_o, r_sel, r_we_bad, r_stb_bad);
    end
  endtask

  task automatic test_read_sel_zero();
    run_txn(1'b0, 32'h20, 32'h1234_5678, 4'h0, 0, 0, 1'b0, 1'b0, 32'h20);
    checks++; if (r_lat !== 2 || r_status !== 2'd0 || r_dat !== 32'h20) begin
      errors++; $display("FAIL read_rsp: lat=%0d st=%0d dat=%h, required 2/0/20", r_lat, r_status, r_dat);
    end
    checks++; if (r_sel !== 4'hF || r_dat_o !== 32'd0 || r_we_bad) begin
      errors++; $display("FAIL read_bus: sel=%h dat_o=%h we_bad=%b, required f/0/0", r_sel, r_dat_o, r_we_bad);
    end
  endtask

  task automatic test_back_to_back();
    int hs0 = -1, hs1 = -1, nhs = 0, nrsp = 0;
    logic [31:0] last_dat = 32'd0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 32'h20; cmd_sel = 4'hF; cmd_dat = 32'd0;
    for (int n = 0; n < 14; n++) begin
      ack_i = 1'b0;
      if (nhs == 1) cmd_adr = 32'h24;
      if (nhs == 2) cmd_valid = 1'b0;
      if (rsp_valid) begin nrsp++; last_dat = rsp_dat; end
      if (cyc_o) begin ack_i = 1'b1; dat_i = adr_o; end
      if (cmd_valid && cmd_ready) begin
        if (nhs == 0) hs0 = n; else hs1 = n;
        nhs++;
      end
      @(negedge clk);
    end
    ack_i = 1'b0; cmd_valid = 1'b0;
    checks++; if (nhs !== 2 || hs1 - hs0 !== 3) begin
      errors++; $display("FAIL b2b_period: handshakes=%0d period=%0d, required 2/3", nhs, hs1 - hs0);
    end
    checks++; if (nrsp !== 2 || last_dat !== 32'h24) begin
      errors++; $display("FAIL b2b_rsp: pulses=%0d dat=%h, required 2/24", nrsp, last_dat);
    end
  endtask

  task automatic test_retry_then_ack();
    run_txn(1'b0, 32'h40, 32'd0, 4'h3, 0, 2, 1'b0, 1'b0, 32'hCAFE_0001);
    checks++; if (r_phases !== 3 || r_gaps !== 2 || r_cyc_hi !== 3 || r_lat !== 6) begin
      errors++; $display("FAIL retry_shape: phases=%0d gaps=%0d cyc=%0d lat=%0d, required 3/2/3/6", r_phases, r_gaps, r_cyc_hi, r_lat);
    end
    checks++; if (r_status !== 2'd0 || r_dat !== 32'hCAFE_0001 || r_adr !== 32'h40 || r_sel !== 4'h3) begin
      errors++; $display("FAIL retry_rsp: st=%0d dat=%h adr=%h sel=%h, required 0/cafe0001/40/3", r_status, r_dat, r_adr, r_sel);
    end
  endtask

  task automatic test_retry_exhausted();
    run_txn(1'b1, 32'h44, 32'h5555_AAAA, 4'hF, 0, 10, 1'b0, 1'b0, 32'd0);
    checks++; if (r_phases !== 4 || r_gaps !== 3 || r_lat !== 8) begin
      errors++; $display("FAIL rty_exh_shape: phases=%0d gaps=%0d lat=%0d, required 4/3/8", r_phases, r_gaps, r_lat);
    end
    checks++; if (r_status !== 2'd2 || r_rsp_cnt !== 1) begin
      errors++; $display("FAIL rty_exh_rsp: st=%0d pulses=%0d, required 2/1", r_status, r_rsp_cnt);
    end
  endtask

  task automatic test_err_ack();
    run_txn(1'b0, 32'h48, 32'd0, 4'hF, 1, 0, 1'b1, 1'b0, 32'd0);
    checks++; if (r_status !== 2'd1 || r_dat !== 32'd0 || r_lat !== 3) begin
      errors++; $display("FAIL err_ack: st=%0d dat=%h lat=%0d, required 1/0/3", r_status, r_dat, r_lat);
    end
  endtask

  task automatic test_timeout();
    run_txn(1'b0, 32'h4C, 32'd0, 4'hF, 0, 0, 1'b0, 1'b1, 32'd0);
    checks++; if (r_cyc_hi !== 8 || r_phases !== 1 || r_lat !== 9) begin
      errors++; $display("FAIL timeout_shape: cyc=%0d phases=%0d lat=%0d, required 8/1/9", r_cyc_hi, r_phases, r_lat);
    end
    checks++; if (r_status !== 2'd3 || r_dat !== 32'd0) begin
      errors++; $display("FAIL timeout_rsp: st=%0d dat=%h, required 3/0", r_status, r_dat);
    end
  endtask

  task automatic test_reset_mid();
    int pulses = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 32'h80; cmd_sel = 4'hF;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (cyc_o !== 1'b1) begin
      errors++; $display("FAIL mid_pre: cyc=%b, required 1", cyc_o);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (cyc_o !== 1'b0 || rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || adr_o !== 32'd0) begin
      errors++; $display("FAIL mid_reset: cyc=%b rsp_valid=%b ready=%b adr=%h, required 0/0/1/0", cyc_o, rsp_valid, cmd_ready, adr_o);
    end
    for (int i = 0; i < 10; i++) begin
      ack_i = 1'b1;
      if (rsp_valid || cyc_o) pulses++;
      @(negedge clk);
    end
    ack_i = 1'b0;
    checks++; if (pulses !== 0) begin
      errors++; $display("FAIL mid_silent: activity=%0d, required 0", pulses);
    end
    run_txn(1'b1, 32'h90, 32'h0BAD_F00D, 4'h1, 0, 0, 1'b0, 1'b0, 32'd0);
    checks++; if (r_status !== 2'd0 || r_lat !== 2 || r_adr !== 32'h90 || r_dat_o !== 32'h0BAD_F00D || r_sel !== 4'h1) begin
      errors++; $display("FAIL mid_fresh: st=%0d lat=%0d adr=%h dat=%h sel=%h, required 0/2/90/0badf00d/1", r_status, r_lat, r_adr, r_dat_o, r_sel);
    end
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = 32'd0; cmd_dat = 32'd0;
    cmd_sel = 4'd0; dat_i = 32'd0; ack_i = 1'b0; err_i = 1'b0; rty_i = 1'b0;
    test_reset();
    test_write();
    test_read_sel_zero();
    test_back_to_back();
    test_retry_then_ack();
    test_retry_exhausted();
    test_err_ack();
    test_timeout();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
